// File: rtl/nec_prefetch_queue_pkg.sv
// rtl/nec_prefetch_queue_pkg.sv - shared types and constants for the instruction prefetch queue
package nec_prefetch_queue_pkg;

    localparam int PREFETCH_DEPTH_DEFAULT = 6;
    localparam int PREFETCH_IP_W          = 16;

    typedef struct packed {
        logic [3:0]               q_len;
        logic [7:0]               q0;
        logic [7:0]               q1;
        logic [7:0]               q2;
        logic [PREFETCH_IP_W-1:0] ip;
    } prefetch_status_t;

    // Illegal count 3 is treated as a 2-byte delivery; 0 stores nothing.
    function automatic logic [1:0] wr_bytes(input logic [1:0] wr_count);
        return (wr_count == 2'd3) ? 2'd2 : wr_count;
    endfunction

endpackage

// File: rtl/nec_prefetch_queue_if.sv
// rtl/nec_prefetch_queue_if.sv - bus/decoder signal bundle; pfq_error present with NEC_PREFETCH_CHECK_EN
interface nec_prefetch_queue_if #(
    parameter int IP_W = 16
);
    logic            flush;
    logic [IP_W-1:0] flush_ip;
    logic            wr_valid;
    logic [15:0]     wr_data;
    logic [1:0]      wr_count;
    logic            wr_ready;
    logic            want_fetch;
    logic [IP_W-1:0] fetch_ip;
    logic [2:0]      consume;
    logic [3:0]      q_len;
    logic [7:0]      q0;
    logic [7:0]      q1;
    logic [7:0]      q2;
    logic [IP_W-1:0] ip;
`ifdef NEC_PREFETCH_CHECK_EN
    logic            pfq_error;

    modport master (
        output flush, flush_ip, wr_valid, wr_data, wr_count, consume,
        input  wr_ready, want_fetch, fetch_ip, q_len, q0, q1, q2, ip, pfq_error
    );
    modport slave (
        input  flush, flush_ip, wr_valid, wr_data, wr_count, consume,
        output wr_ready, want_fetch, fetch_ip, q_len, q0, q1, q2, ip, pfq_error
    );
`else
    modport master (
        output flush, flush_ip, wr_valid, wr_data, wr_count, consume,
        input  wr_ready, want_fetch, fetch_ip, q_len, q0, q1, q2, ip
    );
    modport slave (
        input  flush, flush_ip, wr_valid, wr_data, wr_count, consume,
        output wr_ready, want_fetch, fetch_ip, q_len, q0, q1, q2, ip
    );
`endif
endinterface

// File: rtl/nec_prefetch_ptr.sv
// rtl/nec_prefetch_ptr.sv - modulo-DEPTH pointer adder (ptr + n, n <= 7) without a divider
module nec_prefetch_ptr #(
    parameter int DEPTH = 6
) (
    input  logic [3:0] ptr,
    input  logic [2:0] n,
    output logic [3:0] sum
);
    localparam logic [4:0] DEPTH_W = 5'(DEPTH);

    logic [4:0] raw;
    logic [4:0] once;

    // ptr + n <= DEPTH + 6 < 3*DEPTH for DEPTH >= 4, so two subtractions always suffice.
    always_comb begin
        raw  = {1'b0, ptr} + {2'b00, n};
        once = (raw >= DEPTH_W) ? raw - DEPTH_W : raw;
        sum  = (once >= DEPTH_W) ? 4'(once - DEPTH_W) : once[3:0];
    end
endmodule

// File: rtl/nec_prefetch_queue.sv
// rtl/nec_prefetch_queue.sv - instruction prefetch byte queue; NEC_PREFETCH_CHECK_EN adds sticky pfq_error
module nec_prefetch_queue
    import nec_prefetch_queue_pkg::*;
#(
    parameter int DEPTH = PREFETCH_DEPTH_DEFAULT,
    parameter int IP_W  = PREFETCH_IP_W
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 ce,
    nec_prefetch_queue_if.slave  pif
);
    logic [7:0]      mem [0:15];
    logic [3:0]      rd_ptr;
    logic [3:0]      wr_ptr;
    logic [3:0]      count;
    logic [IP_W-1:0] ip_r;
    logic [IP_W-1:0] fetch_ip_r;

    logic [4:0]      free;
    logic [2:0]      eff_consume;
    logic            wr_accept;
    logic [1:0]      wr_n;
    logic [3:0]      rd_next;
    logic [3:0]      wr_next;
    logic [3:0]      wr_ptr_p1;
    logic [3:0]      rd_ptr_p1;
    logic [3:0]      rd_ptr_p2;
    prefetch_status_t status;

    assign free        = 5'(DEPTH) - {1'b0, count};
    assign eff_consume = ({1'b0, pif.consume} > count) ? count[2:0] : pif.consume;
    assign pif.wr_ready = free >= {3'b000, pif.wr_count};
    assign wr_accept   = !reset && ce && pif.wr_valid && pif.wr_ready && !pif.flush;
    assign wr_n        = wr_accept ? wr_bytes(pif.wr_count) : 2'd0;

    nec_prefetch_ptr #(.DEPTH(DEPTH)) u_rd_next (.ptr(rd_ptr), .n(eff_consume),     .sum(rd_next));
    nec_prefetch_ptr #(.DEPTH(DEPTH)) u_wr_next (.ptr(wr_ptr), .n({1'b0, wr_n}),    .sum(wr_next));
    nec_prefetch_ptr #(.DEPTH(DEPTH)) u_wr_p1   (.ptr(wr_ptr), .n(3'd1),            .sum(wr_ptr_p1));
    nec_prefetch_ptr #(.DEPTH(DEPTH)) u_rd_p1   (.ptr(rd_ptr), .n(3'd1),            .sum(rd_ptr_p1));
    nec_prefetch_ptr #(.DEPTH(DEPTH)) u_rd_p2   (.ptr(rd_ptr), .n(3'd2),            .sum(rd_ptr_p2));

    always_ff @(posedge clk) begin
        if (reset) begin
            count      <= 4'd0;
            rd_ptr     <= 4'd0;
            wr_ptr     <= 4'd0;
            ip_r       <= '0;
            fetch_ip_r <= '0;
        end else if (ce) begin
            if (pif.flush) begin
                count      <= 4'd0;
                rd_ptr     <= 4'd0;
                wr_ptr     <= 4'd0;
                ip_r       <= pif.flush_ip;
                fetch_ip_r <= pif.flush_ip;
            end else begin
                // Consume is clamped against the pre-write count, so fresh bytes survive this cycle.
                count      <= count - {1'b0, eff_consume} + {2'b00, wr_n};
                rd_ptr     <= rd_next;
                wr_ptr     <= wr_next;
                ip_r       <= ip_r + IP_W'(eff_consume);
                fetch_ip_r <= fetch_ip_r + IP_W'(wr_n);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem[wr_ptr] <= pif.wr_data[7:0];
            if (wr_n == 2'd2)
                mem[wr_ptr_p1] <= pif.wr_data[15:8];
        end
    end

    always_comb begin
        status.q_len = count;
        status.q0    = (count > 4'd0) ? mem[rd_ptr]    : 8'h00;
        status.q1    = (count > 4'd1) ? mem[rd_ptr_p1] : 8'h00;
        status.q2    = (count > 4'd2) ? mem[rd_ptr_p2] : 8'h00;
        status.ip    = PREFETCH_IP_W'(ip_r);
    end

    assign pif.q_len      = status.q_len;
    assign pif.q0         = status.q0;
    assign pif.q1         = status.q1;
    assign pif.q2         = status.q2;
    assign pif.ip         = IP_W'(status.ip);
    assign pif.fetch_ip   = fetch_ip_r;
    assign pif.want_fetch = (free >= 5'd2) && !pif.flush;

`ifdef NEC_PREFETCH_CHECK_EN
    logic pfq_error_r;

    always_ff @(posedge clk) begin
        if (reset)
            pfq_error_r <= 1'b0;
        else if (ce && (({1'b0, pif.consume} > count) ||
                        (pif.wr_valid && (pif.wr_count == 2'd0 || pif.wr_count == 2'd3)) ||
                        (pif.wr_valid && !pif.wr_ready)))
            pfq_error_r <= 1'b1;
    end

    assign pif.pfq_error = pfq_error_r;
`endif
endmodule

// File: tb/tb_nec_prefetch_queue.sv
// tb/tb_nec_prefetch_queue.sv - directed and random checks of nec_prefetch_queue against a byte-queue model
module tb_nec_prefetch_queue;
    localparam int DEPTH = 6;

    logic clk = 1'b0;
    logic reset;
    logic ce;
    int   tests_run = 0;
    int   tests_failed = 0;

    byte unsigned m_q[$];
    logic [15:0]  m_ip;
    logic [15:0]  m_fip;

    nec_prefetch_queue_if #(.IP_W(16)) pif ();

    nec_prefetch_queue #(.DEPTH(DEPTH), .IP_W(16)) dut (
        .clk   (clk),
        .reset (reset),
        .ce    (ce),
        .pif   (pif)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        assert (got === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] m_at(input int i);
        return (i < m_q.size()) ? m_q[i] : 8'h00;
    endfunction

    task automatic check_state();
        chk("q_len", 32'(pif.q_len), 32'(m_q.size()));
        chk("q0", 32'(pif.q0), 32'(m_at(0)));
        chk("q1", 32'(pif.q1), 32'(m_at(1)));
        chk("q2", 32'(pif.q2), 32'(m_at(2)));
        chk("ip", 32'(pif.ip), 32'(m_ip));
        chk("fetch_ip", 32'(pif.fetch_ip), 32'(m_fip));
    endtask

    // Drive one cycle's inputs, check handshake outputs, clock, update the model, check state.
    task automatic cycle(input logic c, input logic fl, input logic [15:0] fip,
                         input logic wv, input logic [15:0] wd, input logic [1:0] wc,
                         input logic [2:0] cons);
        bit exp_ready;
        int e;
        ce = c;
        pif.flush = fl;
        pif.flush_ip = fip;
        pif.wr_valid = wv;
        pif.wr_data = wd;
        pif.wr_count = wc;
        pif.consume = cons;
        #1;
        exp_ready = (DEPTH - m_q.size()) >= int'(wc);
        chk("wr_ready", 32'(pif.wr_ready), 32'(exp_ready));
        chk("want_fetch", 32'(pif.want_fetch), 32'((DEPTH - m_q.size()) >= 2 && !fl));
        @(posedge clk);
        if (c) begin
            if (fl) begin
                m_q.delete();
                m_ip = fip;
                m_fip = fip;
            end else begin
                e = (int'(cons) > m_q.size()) ? m_q.size() : int'(cons);
                for (int i = 0; i < e; i++) void'(m_q.pop_front());
                m_ip = m_ip + 16'(e);
                if (wv && exp_ready) begin
                    m_q.push_back(wd[7:0]);
                    if (wc == 2'd2) m_q.push_back(wd[15:8]);
                    m_fip = m_fip + 16'(wc);
                end
            end
        end
        #1;
        check_state();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        ce = 1'b0;
        pif.flush = 1'b0;
        pif.flush_ip = 16'h0;
        pif.wr_valid = 1'b0;
        pif.wr_data = 16'h0;
        pif.wr_count = 2'd1;
        pif.consume = 3'd0;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        m_q.delete();
        m_ip = 16'h0;
        m_fip = 16'h0;
    endtask

    initial begin
        do_reset();
        chk("rst_q_len", 32'(pif.q_len), 32'd0);
        chk("rst_q0", 32'(pif.q0), 32'd0);
        chk("rst_q1", 32'(pif.q1), 32'd0);
        chk("rst_q2", 32'(pif.q2), 32'd0);
        chk("rst_ip", 32'(pif.ip), 32'd0);
        chk("rst_fetch_ip", 32'(pif.fetch_ip), 32'd0);
        chk("rst_wr_ready", 32'(pif.wr_ready), 32'd1);
        chk("rst_want_fetch", 32'(pif.want_fetch), 32'd1);
        cycle(1, 0, 16'h0, 0, 16'h0, 2'd1, 3'd0);

        cycle(1, 0, 16'h0, 1, 16'h3412, 2'd2, 3'd0);
        cycle(1, 0, 16'h0, 1, 16'h0056, 2'd1, 3'd0);
        chk("fill_q_len", 32'(pif.q_len), 32'd3);
        chk("fill_q0", 32'(pif.q0), 32'h12);
        chk("fill_q1", 32'(pif.q1), 32'h34);
        chk("fill_q2", 32'(pif.q2), 32'h56);
        chk("fill_fetch_ip", 32'(pif.fetch_ip), 32'd3);
        cycle(1, 0, 16'h0, 0, 16'h0, 2'd1, 3'd2);
        chk("rd_q_len", 32'(pif.q_len), 32'd1);
        chk("rd_q0", 32'(pif.q0), 32'h56);
        chk("rd_q1", 32'(pif.q1), 32'h00);
        chk("rd_ip", 32'(pif.ip), 32'd2);
        cycle(1, 0, 16'h0, 0, 16'h0, 2'd1, 3'd1);

        cycle(1, 0, 16'h0, 1, 16'h0201, 2'd2, 3'd0);
        cycle(1, 0, 16'h0, 1, 16'h0403, 2'd2, 3'd0);
        cycle(1, 0, 16'h0, 1, 16'h0605, 2'd2, 3'd0);
        pif.wr_count = 2'd1;
        #1;
        chk("full_wr_ready", 32'(pif.wr_ready), 32'd0);
        chk("full_want_fetch", 32'(pif.want_fetch), 32'd0);
        cycle(1, 0, 16'h0, 1, 16'h00ee, 2'd1, 3'd0);
        chk("full_held_q_len", 32'(pif.q_len), 32'd6);
        cycle(1, 0, 16'h0, 0, 16'h0, 2'd1, 3'd3);
        cycle(1, 0, 16'h0, 1, 16'h0807, 2'd2, 3'd0);
        chk("wrap_q_len", 32'(pif.q_len), 32'd5);
        chk("wrap_q0", 32'(pif.q0), 32'h04);
        chk("wrap_q2", 32'(pif.q2), 32'h06);

        cycle(1, 0, 16'h0, 0, 16'h0, 2'd1, 3'd1);
        cycle(1, 0, 16'h0, 1, 16'h0a09, 2'd2, 3'd2);
        chk("simul_q_len", 32'(pif.q_len), 32'd4);
        chk("simul_q0", 32'(pif.q0), 32'h07);
        chk("simul_q2", 32'(pif.q2), 32'h09);

        cycle(1, 0, 16'h0, 1, 16'h000b, 2'd1, 3'd0);
        cycle(1, 1, 16'h1235, 1, 16'hbbaa, 2'd2, 3'd0);
        chk("flush_q_len", 32'(pif.q_len), 32'd0);
        chk("flush_ip", 32'(pif.ip), 32'h1235);
        chk("flush_fetch_ip", 32'(pif.fetch_ip), 32'h1235);

        cycle(1, 0, 16'h0, 1, 16'h00cc, 2'd1, 3'd0);
        cycle(0, 1, 16'h4444, 1, 16'h1111, 2'd2, 3'd1);
        cycle(0, 0, 16'h0, 1, 16'h2222, 2'd2, 3'd1);
        chk("ce0_q_len", 32'(pif.q_len), 32'd1);
        chk("ce0_q0", 32'(pif.q0), 32'hcc);
        chk("ce0_fetch_ip", 32'(pif.fetch_ip), 32'h1236);

        cycle(1, 0, 16'h0, 1, 16'h00dd, 2'd1, 3'd0);
        cycle(1, 0, 16'h0, 0, 16'h0, 2'd1, 3'd4);
        chk("over_q_len", 32'(pif.q_len), 32'd0);
        chk("over_ip", 32'(pif.ip), 32'h1237);
`ifdef NEC_PREFETCH_CHECK_EN
        chk("pfq_error_set", 32'(pif.pfq_error), 32'd1);
        cycle(1, 0, 16'h0, 0, 16'h0, 2'd1, 3'd0);
        cycle(1, 0, 16'h0, 0, 16'h0, 2'd1, 3'd0);
        chk("pfq_error_sticky", 32'(pif.pfq_error), 32'd1);
        do_reset();
        chk("pfq_error_rst", 32'(pif.pfq_error), 32'd0);
`endif

        for (int n = 0; n < 500; n++) begin
            cycle($urandom_range(0, 9) != 0,
                  $urandom_range(0, 24) == 0,
                  16'($urandom),
                  $urandom_range(0, 2) != 0,
                  16'($urandom),
                  2'($urandom_range(1, 2)),
                  ($urandom_range(0, 7) == 0) ? 3'($urandom_range(0, 7)) : 3'($urandom_range(0, 2)));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/nec_prefetch_queue.md
Name: nec_prefetch_queue

Overview:
- Instruction prefetch byte queue. Sits directly upstream of the instruction decoder and feeds it `q0`/`q1`/`q2`/`q_len`.
- Accepts 1- or 2-byte fetch results from the bus interface and retires bytes as the sequencer consumes decoded instructions.
- Tracks the fetch offset and the current instruction offset (IP).
- Empties on flush: branch, interrupt or segment reload.

Parameters:
- DEPTH, 6, queue capacity in bytes; legal range 4..15, because q_len is 4 bits.
- IP_W, 16, width of the fetch and instruction offset counters.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- ce  in  1  clock enable; state advances only when ce=1
- flush  in  1  discard all queued bytes and restart fetch at flush_ip
- flush_ip  in  IP_W  new offset loaded on flush
- wr_valid  in  1  bus delivers fetched bytes
- wr_data  in  16  fetched bytes; [7:0] is the first byte in program order
- wr_count  in  2  number of valid bytes in wr_data (1 or 2; 0 and 3 are illegal)
- wr_ready  out  1  queue has room for wr_count bytes
- want_fetch  out  1  at least 2 bytes free and no flush this cycle; bus may start a fetch
- fetch_ip  out  IP_W  offset of the next byte to fetch
- consume  in  3  bytes retired this cycle (0..7)
- q_len  out  4  valid bytes queued
- q0  out  8  oldest byte
- q1  out  8  next byte
- q2  out  8  byte after q1
- ip  out  IP_W  offset of q0

Behaviour:
- Circular byte buffer of DEPTH entries with rd_ptr, wr_ptr and a count register.
  - Pointers wrap modulo DEPTH; DEPTH need not be a power of 2.
- Reset (when reset=1 in any cycle, ce ignored):
  - count=0, pointers=0, fetch_ip=0, ip=0.
  - Outputs: q_len=0, q0..q2=0, wr_ready=1, want_fetch=1.
- q_len equals count.
- q0/q1/q2 are combinational reads at rd_ptr, rd_ptr+1 and rd_ptr+2 (mod DEPTH).
  - Any qN with N >= q_len reads 8'h00, so decode sees deterministic zeros.
- wr_ready = (DEPTH - count) >= wr_count. It is computed from the pre-consume count (conservative, no combinational path from consume).
- Write is accepted when ce && wr_valid && wr_ready && !flush.
  - Store wr_count bytes at wr_ptr.
  - wr_ptr += wr_count; fetch_ip += wr_count (wraps at 2^IP_W).
- Consume:
  - Effective consume = min(consume, count) when ce && !flush.
  - rd_ptr += effective consume; ip += effective consume.
- Simultaneous write and consume: count_next = count - eff_consume + accepted_wr_count, resolved in one cycle.
  - A byte written this cycle is never consumed this cycle.
- Flush has priority over everything, provided ce=1:
  - count=0, rd_ptr=wr_ptr=0, ip=fetch_ip=flush_ip.
  - A same-cycle write is dropped and wr_ready is ignored.
  - Consume is ignored.
- Flush with ce=0 has no effect; the caller holds flush until ce.
- want_fetch = (DEPTH - count >= 2) && !flush. This is combinational from registered count.
- Full (count=DEPTH): wr_ready=0; a wr_valid request is held off.
- Empty (count=0): q_len=0, q0..q2=0, consume ignored.
- ce=0: all registers hold; outputs are still driven from state.
- Latency: a byte written in cycle N is visible on q0..q2 in cycle N+1.

Optional Feature:
- Macro: NEC_PREFETCH_CHECK_EN.
- Defined: the block adds output `pfq_error` (1 bit, sticky, cleared only by reset). It is set on:
  - consume > count;
  - wr_valid with wr_count of 0 or 3;
  - wr_valid && !wr_ready.
- Not defined: the port is absent and the conditions are silently clamped as described under Behaviour.

Decomposition:
- Shared types package: add a `prefetch_status_t` struct (q_len, q0, q1, q2, ip) plus constant `PREFETCH_DEPTH_DEFAULT`=6.
- Sub-module `nec_prefetch_ptr`: modulo-DEPTH pointer adder (ptr + n, n ≤ 7) wrapping without a divider. It is instantiated for rd_ptr, wr_ptr and the q1/q2 read indices.

Test Plan:
- Reset, then idle.
  - Expect q_len=0, q0..q2=0, ip=0, fetch_ip=0, wr_ready=1, want_fetch=1.
- Fill and read.
  - Stimulus: writes 16'h3412 (count 2), 16'h0056 (count 1).
  - Expect q_len=3, q0=12, q1=34, q2=56, fetch_ip=3.
  - Then consume=2: expect q_len=1, q0=56, q1=00, ip=2.
- Full and wrap-around.
  - Fill DEPTH=6 bytes 01..06: expect wr_ready=0, want_fetch=0.
  - consume=3, then write 2 bytes 07,08: expect q0=04, q_len=5. Pointers wrap; q0..q2 correct across the wrap.
- Simultaneous write and consume.
  - With count=4, apply consume=2 and a 2-byte write in the same cycle: expect q_len=4, with the new bytes at positions 2..3.
- Flush mid-operation.
  - With count=5, apply flush with flush_ip=16'h1235 plus a same-cycle write: expect q_len=0, ip=fetch_ip=1235, write dropped.
- ce gating and checks.
  - Write, consume and flush with ce=0: state unchanged.
  - With NEC_PREFETCH_CHECK_EN defined, consume=4 with count=2: expect q_len=0 and pfq_error=1, held until reset.
